// File: rtl/gpu_pkg.sv
// Shared GPU definitions: memory-channel FSM encoding and round-robin helpers.
// Pure declarations with no latency; used by the arbiter, lsu and fetcher.
package gpu_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_READ_WAIT   = 3'd1;
  localparam logic [2:0] ST_WRITE_WAIT  = 3'd2;
  localparam logic [2:0] ST_READ_RELAY  = 3'd3;
  localparam logic [2:0] ST_WRITE_RELAY = 3'd4;

  typedef enum logic [2:0] {
    IDLE        = ST_IDLE,
    READ_WAIT   = ST_READ_WAIT,
    WRITE_WAIT  = ST_WRITE_WAIT,
    READ_RELAY  = ST_READ_RELAY,
    WRITE_RELAY = ST_WRITE_RELAY
  } mem_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Find-first requester at or above ptr (wrapping), skipping masked entries.
// Purely combinational; no backpressure.
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] elig;
  assign elig = req & ~mask;

  // Walk offsets from farthest to nearest so the nearest eligible entry wins.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (elig[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: each channel round-robins LSU consumers onto one external port.
// Ack 2 edges after request at best; mem ready stalls hold requests stable, consumers hold valid until acked.
module mem_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  logic [NUM_CONSUMERS-1:0] req;
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CONSUMERS-1:0] mask     [NUM_CHANNELS];
  mem_state_t               ch_state [NUM_CHANNELS];
  logic [CW-1:0]            ch_owner [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0]           rd_rdy_q;
  logic [NUM_CONSUMERS-1:0]           wr_rdy_q;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_dat_q;

  assign req = consumer_read_valid | consumer_write_valid;

  // A consumer is claimed for as long as some channel is busy on its behalf.
  always_comb begin
    claimed = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (ch_state[ch] != IDLE) claimed[ch_owner[ch]] = 1'b1;
    end
  end

  assign mask[0] = claimed;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    mem_state_t           state_q;
    logic [CW-1:0]        ptr_q;
    logic [CW-1:0]        owner_q;
    logic                 rd_vld_q;
    logic                 wr_vld_q;
    logic [ADDR_BITS-1:0] rd_addr_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic [DATA_BITS-1:0] wr_data_q;
    logic                 found;
    logic [CW-1:0]        pick;

    rr_pick #(.N(NUM_CONSUMERS), .IW(CW)) u_pick (
      .req   (req),
      .mask  (mask[g]),
      .ptr   (ptr_q),
      .found (found),
      .idx   (pick)
    );

    // Lower channels win same-cycle contention: hide our pick from the next channel.
    if (g < NUM_CHANNELS - 1) begin : g_chain
      logic take;
      assign take       = (state_q == IDLE) && found;
      assign mask[g+1]  = mask[g] | (take ? (NUM_CONSUMERS'(1) << pick) : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= IDLE;
        ptr_q     <= '0;
        owner_q   <= '0;
        rd_vld_q  <= 1'b0;
        wr_vld_q  <= 1'b0;
        rd_addr_q <= '0;
        wr_addr_q <= '0;
        wr_data_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (found) begin
              owner_q <= pick;
              ptr_q   <= CW'(rr_next(int'(pick), NUM_CONSUMERS));
              if (consumer_read_valid[pick]) begin
                rd_vld_q  <= 1'b1;
                rd_addr_q <= consumer_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                state_q   <= READ_WAIT;
              end else begin
                wr_vld_q  <= 1'b1;
                wr_addr_q <= consumer_write_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                wr_data_q <= consumer_write_data[int'(pick)*DATA_BITS +: DATA_BITS];
                state_q   <= WRITE_WAIT;
              end
            end
          end
          READ_WAIT: begin
            if (mem_read_ready[g]) begin
              rd_vld_q <= 1'b0;
              state_q  <= READ_RELAY;
            end
          end
          WRITE_WAIT: begin
            if (mem_write_ready[g]) begin
              wr_vld_q <= 1'b0;
              state_q  <= WRITE_RELAY;
            end
          end
          READ_RELAY: begin
            if (!consumer_read_valid[owner_q]) state_q <= IDLE;
          end
          WRITE_RELAY: begin
            if (!consumer_write_valid[owner_q]) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign ch_state[g] = state_q;
    assign ch_owner[g] = owner_q;

    assign mem_read_valid[g]                             = rd_vld_q;
    assign mem_read_address[g*ADDR_BITS +: ADDR_BITS]    = rd_addr_q;
    assign mem_write_valid[g]                            = wr_vld_q;
    assign mem_write_address[g*ADDR_BITS +: ADDR_BITS]   = wr_addr_q;
    assign mem_write_data[g*DATA_BITS +: DATA_BITS]      = wr_data_q;
  end

  // Consumer-facing acks mirror the owning channel's WAIT->RELAY->IDLE transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_rdy_q <= '0;
      wr_rdy_q <= '0;
      rd_dat_q <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (ch_state[ch] == READ_WAIT && mem_read_ready[ch]) begin
          rd_rdy_q[ch_owner[ch]] <= 1'b1;
          rd_dat_q[int'(ch_owner[ch])*DATA_BITS +: DATA_BITS] <= mem_read_data[ch*DATA_BITS +: DATA_BITS];
        end
        if (ch_state[ch] == READ_RELAY && !consumer_read_valid[ch_owner[ch]])
          rd_rdy_q[ch_owner[ch]] <= 1'b0;
        if (ch_state[ch] == WRITE_WAIT && mem_write_ready[ch])
          wr_rdy_q[ch_owner[ch]] <= 1'b1;
        if (ch_state[ch] == WRITE_RELAY && !consumer_write_valid[ch_owner[ch]])
          wr_rdy_q[ch_owner[ch]] <= 1'b0;
      end
    end
  end

  assign consumer_read_ready  = rd_rdy_q;
  assign consumer_read_data   = rd_dat_q;
  assign consumer_write_ready = wr_rdy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle checks on a 1-channel instance, contention and
// randomized traffic against a memory-image reference model on a 2-channel instance.
module tb_mem_arbiter;

  localparam int NC = 8;
  localparam int AB = 8;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 1-channel instance
  logic [NC-1:0]    a_rv, a_rr, a_wv, a_wr;
  logic [NC*AB-1:0] a_ra, a_wa;
  logic [NC*DB-1:0] a_rd, a_wd;
  logic             a_mrv, a_mrr, a_mwv, a_mwr;
  logic [AB-1:0]    a_mra, a_mwa;
  logic [DB-1:0]    a_mrd, a_mwd;

  mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(AB), .DATA_BITS(DB)) u_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
    .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
    .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
    .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  // 2-channel instance backed by a bench memory
  logic [NC-1:0]    b_rv, b_rr, b_wv, b_wr;
  logic [NC*AB-1:0] b_ra, b_wa;
  logic [NC*DB-1:0] b_rd, b_wd;
  logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr;
  logic [2*AB-1:0]  b_mra, b_mwa;
  logic [2*DB-1:0]  b_mrd, b_mwd;
  logic             b_mode = 1'b0;
  logic [3:0]       b_rnd = 4'hF;
  logic [7:0]       bmem [256];

  mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2), .ADDR_BITS(AB), .DATA_BITS(DB)) u_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
    .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  always @(negedge clk) b_rnd = 4'($urandom);
  assign b_mrr = b_mode ? b_rnd[1:0] : 2'b11;
  assign b_mwr = b_mode ? b_rnd[3:2] : 2'b11;
  assign b_mrd = {bmem[b_mra[15:8]], bmem[b_mra[7:0]]};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) bmem[i] <= pat(i);
    end else begin
      for (int ch = 0; ch < 2; ch++)
        if (b_mwv[ch] && b_mwr[ch]) bmem[b_mwa[ch*AB +: AB]] <= b_mwd[ch*DB +: DB];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0;
    a_mrr = 1'b0; a_mwr = 1'b0; a_mrd = '0;
    b_rv = '0; b_wv = '0; b_ra = '0; b_wa = '0; b_wd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    a_rv = '1; a_mrr = 1'b1; a_mwr = 1'b1; b_wv = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_mrv, a_mwv, a_rr, a_wr} !== '0) begin
      failures++; $display("FAIL reset_a_ctrl got=%0h exp=0", {a_mrv, a_mwv, a_rr, a_wr});
    end
    checks++;
    if ({a_mra, a_mwa, a_mwd, a_rd} !== '0) begin
      failures++; $display("FAIL reset_a_data got=%0h exp=0", {a_mra, a_mwa, a_mwd, a_rd});
    end
    checks++;
    if ({b_mrv, b_mwv, b_rr, b_wr} !== '0) begin
      failures++; $display("FAIL reset_b_ctrl got=%0h exp=0", {b_mrv, b_mwv, b_rr, b_wr});
    end
    checks++;
    if ({b_mra, b_mwa, b_mwd, b_rd} !== '0) begin
      failures++; $display("FAIL reset_b_data got=%0h exp=0", {b_mra, b_mwa, b_mwd, b_rd});
    end
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    a_mrr = 1'b1; a_mrd = 8'hAB;
    a_ra[3*AB +: AB] = 8'h10; a_rv[3] = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_mrv, a_mra, a_rr} !== {1'b1, 8'h10, 8'h00}) begin
      failures++; $display("FAIL single_read_issue got=%0h exp=%0h", {a_mrv, a_mra, a_rr}, {1'b1, 8'h10, 8'h00});
    end
    @(negedge clk);
    checks++;
    if ({a_mrv, a_rr, a_rd[3*DB +: DB]} !== {1'b0, 8'h08, 8'hAB}) begin
      failures++; $display("FAIL single_read_ack got=%0h exp=%0h", {a_mrv, a_rr, a_rd[3*DB +: DB]}, {1'b0, 8'h08, 8'hAB});
    end
    a_rv[3] = 1'b0;
    a_mrd = 8'h00;
    @(negedge clk);
    checks++;
    if ({a_rr, a_rd[3*DB +: DB]} !== {8'h00, 8'hAB}) begin
      failures++; $display("FAIL single_read_release got=%0h exp=%0h", {a_rr, a_rd[3*DB +: DB]}, {8'h00, 8'hAB});
    end
    @(negedge clk);
    checks++;
    if ({a_mrv, a_rr} !== '0) begin
      failures++; $display("FAIL ready_without_valid got=%0h exp=0", {a_mrv, a_rr});
    end
  endtask

  task automatic test_abort();
    a_mrr = 1'b0; a_mrd = 8'h3C;
    a_ra[4*AB +: AB] = 8'h21; a_rv[4] = 1'b1;
    @(negedge clk);
    a_rv[4] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_mrv, a_mra} !== {1'b1, 8'h21}) begin
      failures++; $display("FAIL abort_hold got=%0h exp=%0h", {a_mrv, a_mra}, {1'b1, 8'h21});
    end
    a_mrr = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_rr, a_rd[4*DB +: DB]} !== {8'h10, 8'h3C}) begin
      failures++; $display("FAIL abort_ack got=%0h exp=%0h", {a_rr, a_rd[4*DB +: DB]}, {8'h10, 8'h3C});
    end
    @(negedge clk);
    checks++;
    if (a_rr !== 8'h00) begin
      failures++; $display("FAIL abort_relay_exit got=%0h exp=0", a_rr);
    end
  endtask

  task automatic test_write_stall();
    a_mwr = 1'b0;
    a_wa[1*AB +: AB] = 8'h5A; a_wd[1*DB +: DB] = 8'hC3; a_wv[1] = 1'b1;
    @(negedge clk);
    a_wd[1*DB +: DB] = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({a_mwv, a_mwa, a_mwd, a_wr} !== {1'b1, 8'h5A, 8'hC3, 8'h00}) begin
        failures++; $display("FAIL write_stall_hold cyc=%0d got=%0h exp=%0h", i, {a_mwv, a_mwa, a_mwd, a_wr}, {1'b1, 8'h5A, 8'hC3, 8'h00});
      end
      if (i < 9) @(negedge clk);
    end
    a_mwr = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_mwv, a_wr} !== {1'b0, 8'h02}) begin
      failures++; $display("FAIL write_stall_ack got=%0h exp=%0h", {a_mwv, a_wr}, {1'b0, 8'h02});
    end
    a_wv[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (a_wr !== 8'h00) begin
      failures++; $display("FAIL write_stall_release got=%0h exp=0", a_wr);
    end
  endtask

  task automatic test_read_write_same();
    a_mrr = 1'b1; a_mwr = 1'b1; a_mrd = 8'h77;
    a_ra[5*AB +: AB] = 8'h33; a_wa[5*AB +: AB] = 8'h33; a_wd[5*DB +: DB] = 8'h5C;
    a_rv[5] = 1'b1; a_wv[5] = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_mrv, a_mwv, a_mra} !== {2'b10, 8'h33}) begin
      failures++; $display("FAIL rw_read_first got=%0h exp=%0h", {a_mrv, a_mwv, a_mra}, {2'b10, 8'h33});
    end
    @(negedge clk);
    checks++;
    if ({a_rr, a_rd[5*DB +: DB], a_wr} !== {8'h20, 8'h77, 8'h00}) begin
      failures++; $display("FAIL rw_read_ack got=%0h exp=%0h", {a_rr, a_rd[5*DB +: DB], a_wr}, {8'h20, 8'h77, 8'h00});
    end
    a_rv[5] = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_rr, a_mwv} !== '0) begin
      failures++; $display("FAIL rw_gap got=%0h exp=0", {a_rr, a_mwv});
    end
    @(negedge clk);
    checks++;
    if ({a_mwv, a_mwa, a_mwd} !== {1'b1, 8'h33, 8'h5C}) begin
      failures++; $display("FAIL rw_write_issue got=%0h exp=%0h", {a_mwv, a_mwa, a_mwd}, {1'b1, 8'h33, 8'h5C});
    end
    @(negedge clk);
    checks++;
    if (a_wr !== 8'h20) begin
      failures++; $display("FAIL rw_write_ack got=%0h exp=20", a_wr);
    end
    a_wv[5] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rr_fairness();
    int grants [9];
    int ng;
    logic prev;
    ng = 0; prev = 1'b0;
    clear_inputs();
    do_reset();
    a_mrr = 1'b1;
    for (int c = 0; c < NC; c++) a_ra[c*AB +: AB] = 8'(8'h20 + c);
    a_rv = '1;
    for (int cyc = 0; cyc < 300 && ng < 9; cyc++) begin
      @(negedge clk);
      if (a_mrv && !prev) begin
        grants[ng] = int'(a_mra) - 32;
        ng++;
      end
      prev = a_mrv;
      for (int c = 0; c < NC; c++) begin
        if (a_rr[c] && a_rv[c]) a_rv[c] = 1'b0;
        else if (!a_rr[c] && !a_rv[c]) a_rv[c] = 1'b1;
      end
    end
    a_rv = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (ng != 9) begin
      failures++; $display("FAIL rr_grant_count got=%0d exp=9", ng);
    end
    for (int k = 0; k < ng; k++) begin
      checks++;
      if (grants[k] != k % NC) begin
        failures++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, grants[k], k % NC);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    a_mrr = 1'b0;
    a_ra[2*AB +: AB] = 8'h44; a_rv[2] = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_mrv, a_mra} !== {1'b1, 8'h44}) begin
      failures++; $display("FAIL rst_wait_issue got=%0h exp=%0h", {a_mrv, a_mra}, {1'b1, 8'h44});
    end
    a_ra[7*AB +: AB] = 8'h77; a_rv[7] = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({a_mrv, a_mra, a_rr, a_rd, a_mwv, a_wr} !== '0) begin
      failures++; $display("FAIL rst_wait_async got=%0h exp=0", {a_mrv, a_mra, a_rr, a_rd, a_mwv, a_wr});
    end
    @(negedge clk);
    reset = 1'b1;
    a_mrr = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_mrv, a_mra} !== {1'b1, 8'h44}) begin
      failures++; $display("FAIL rst_wait_regrant got=%0h exp=%0h", {a_mrv, a_mra}, {1'b1, 8'h44});
    end
    a_rv = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_two_channels();
    b_mode = 1'b0;
    b_ra[0 +: AB] = 8'h01; b_ra[AB +: AB] = 8'h02; b_ra[2*AB +: AB] = 8'h03;
    b_rv[2:0] = 3'b111;
    @(negedge clk);
    checks++;
    if ({b_mrv, b_mra} !== {2'b11, 8'h02, 8'h01}) begin
      failures++; $display("FAIL two_ch_grant got=%0h exp=%0h", {b_mrv, b_mra}, {2'b11, 8'h02, 8'h01});
    end
    @(negedge clk);
    checks++;
    if ({b_rr, b_rd[DB +: DB], b_rd[0 +: DB]} !== {8'h03, pat(2), pat(1)}) begin
      failures++; $display("FAIL two_ch_ack got=%0h exp=%0h", {b_rr, b_rd[DB +: DB], b_rd[0 +: DB]}, {8'h03, pat(2), pat(1)});
    end
    b_rv[1:0] = 2'b00;
    @(negedge clk);
    checks++;
    if ({b_rr, b_mrv} !== '0) begin
      failures++; $display("FAIL two_ch_wait got=%0h exp=0", {b_rr, b_mrv});
    end
    @(negedge clk);
    checks++;
    if ({b_mrv, b_mra[7:0]} !== {2'b01, 8'h03}) begin
      failures++; $display("FAIL two_ch_third got=%0h exp=%0h", {b_mrv, b_mra[7:0]}, {2'b01, 8'h03});
    end
    @(negedge clk);
    checks++;
    if ({b_rr, b_rd[2*DB +: DB]} !== {8'h04, pat(3)}) begin
      failures++; $display("FAIL two_ch_third_ack got=%0h exp=%0h", {b_rr, b_rd[2*DB +: DB]}, {8'h04, pat(3)});
    end
    b_rv = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] ref_mem [256];
    logic       busy [NC];
    logic       isrd [NC];
    logic       cool [NC];
    logic [7:0] taddr [NC];
    logic [7:0] tdata [NC];
    int         age [NC];
    int         done;
    logic [2:0] r0, r1;
    done = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    for (int c = 0; c < NC; c++) begin
      busy[c] = 1'b0; isrd[c] = 1'b0; cool[c] = 1'b0; taddr[c] = '0; tdata[c] = '0; age[c] = 0;
    end
    b_mode = 1'b1;
    for (int cyc = 0; cyc < 5000 && done < 200; cyc++) begin
      @(negedge clk);
      if ((b_mrv[0] || b_mwv[0]) && (b_mrv[1] || b_mwv[1])) begin
        r0 = b_mrv[0] ? b_mra[7:5] : b_mwa[7:5];
        r1 = b_mrv[1] ? b_mra[15:13] : b_mwa[15:13];
        checks++;
        if (r0 == r1) begin
          failures++; $display("FAIL rand_double_grant consumer=%0d on both channels", r0);
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (busy[c]) begin
          if (isrd[c] ? b_rr[c] : b_wr[c]) begin
            checks++;
            if (isrd[c]) begin
              if (b_rd[c*DB +: DB] !== ref_mem[taddr[c]]) begin
                failures++; $display("FAIL rand_read c=%0d addr=%0h got=%0h exp=%0h", c, taddr[c], b_rd[c*DB +: DB], ref_mem[taddr[c]]);
              end
              b_rv[c] = 1'b0;
            end else begin
              ref_mem[taddr[c]] = tdata[c];
              b_wv[c] = 1'b0;
            end
            busy[c] = 1'b0; cool[c] = 1'b1; done++;
          end else begin
            age[c]++;
            if (age[c] > 400) begin
              checks++; failures++;
              $display("FAIL rand_timeout c=%0d got=no_ack exp=ack", c);
              b_rv[c] = 1'b0; b_wv[c] = 1'b0; busy[c] = 1'b0;
            end
          end
        end else if (cool[c]) begin
          checks++;
          if ({b_rr[c], b_wr[c]} !== 2'b00) begin
            failures++; $display("FAIL rand_release c=%0d got=%0b exp=00", c, {b_rr[c], b_wr[c]});
          end
          cool[c] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          isrd[c]  = 1'($urandom_range(0, 1));
          taddr[c] = {3'(c), 5'($urandom)};
          tdata[c] = 8'($urandom);
          age[c]   = 0;
          busy[c]  = 1'b1;
          if (isrd[c]) begin
            b_ra[c*AB +: AB] = taddr[c]; b_rv[c] = 1'b1;
          end else begin
            b_wa[c*AB +: AB] = taddr[c]; b_wd[c*DB +: DB] = tdata[c]; b_wv[c] = 1'b1;
          end
        end
      end
    end
    b_rv = '0; b_wv = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (done < 200) begin
      failures++; $display("FAIL rand_progress got=%0d exp>=200", done);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_abort();
    test_write_stall();
    test_read_write_same();
    test_rr_fairness();
    test_reset_in_wait();
    test_two_channels();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 8, the number of LSU requesters (cores x threads).
REQ-002 SHALL have parameter NUM_CHANNELS, default 2, the number of external memory channels.
REQ-003 SHALL have parameter ADDR_BITS, default 8, the address width.
REQ-004 SHALL have parameter DATA_BITS, default 8, the data width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port consumer_read_valid, input, NUM_CONSUMERS bits: per-consumer read request.
REQ-008 SHALL have port consumer_read_address, input, NUM_CONSUMERS*ADDR_BITS bits: flattened, consumer i at slice [i*ADDR_BITS +: ADDR_BITS].
REQ-009 SHALL have port consumer_read_ready, output, NUM_CONSUMERS bits: read data valid/ack.
REQ-010 SHALL have port consumer_read_data, output, NUM_CONSUMERS*DATA_BITS bits: flattened read data.
REQ-011 SHALL have port consumer_write_valid, input, NUM_CONSUMERS bits: per-consumer write request.
REQ-012 SHALL have port consumer_write_address, input, NUM_CONSUMERS*ADDR_BITS bits: flattened.
REQ-013 SHALL have port consumer_write_data, input, NUM_CONSUMERS*DATA_BITS bits: flattened.
REQ-014 SHALL have port consumer_write_ready, output, NUM_CONSUMERS bits: write ack.
REQ-015 SHALL have ports mem_read_valid (output, NUM_CHANNELS), mem_read_address (output, NUM_CHANNELS*ADDR_BITS), mem_read_ready (input, NUM_CHANNELS) and mem_read_data (input, NUM_CHANNELS*DATA_BITS).
REQ-016 SHALL have ports mem_write_valid (output, NUM_CHANNELS), mem_write_address (output, NUM_CHANNELS*ADDR_BITS), mem_write_data (output, NUM_CHANNELS*DATA_BITS) and mem_write_ready (input, NUM_CHANNELS).

Function
REQ-017 Each channel SHALL run an independent FSM with states IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY and WRITE_RELAY.
REQ-018 In IDLE, a channel SHALL scan consumers from its round-robin pointer upward, modulo NUM_CONSUMERS, and grant the first one that is requesting (read_valid or write_valid) and not claimed.
REQ-019 A consumer asserting read_valid and write_valid together SHALL be served as a read; the write waits for a later grant.
REQ-020 Same-cycle grants SHALL resolve in channel-index order: a consumer granted by a lower channel is excluded for higher channels that cycle, so no consumer is ever held by two channels.
REQ-021 On a grant at edge t, the channel SHALL latch the consumer's address (and write data), set its claim bit, set its pointer to (granted+1) mod NUM_CONSUMERS, and drive mem_*_valid high after edge t.
REQ-022 In READ_WAIT, mem_read_valid and address SHALL be held stable until mem_read_ready=1 is sampled.
REQ-023 On sampling mem_read_ready=1, the channel SHALL drop mem_read_valid, drive consumer_read_data with mem_read_data, assert consumer_read_ready and go to READ_RELAY.
REQ-024 WRITE_WAIT SHALL behave like READ_WAIT using mem_write_*, except that no data is returned, and go to WRITE_RELAY.
REQ-025 In either RELAY state, ready and data SHALL be held until the consumer's valid is sampled 0; then ready SHALL drop, the claim SHALL clear and the channel SHALL go to IDLE (a re-grant is possible the following cycle).
REQ-026 Minimum request-to-ack latency SHALL be 2 edges when mem ready is combinational-high.
REQ-027 A consumer dropping valid during a WAIT state SHALL NOT abort the transaction; it completes, and RELAY exits immediately.
REQ-028 mem_*_ready seen while the matching mem_*_valid is low SHALL be ignored.
REQ-029 consumer_read_data for an unserved consumer SHALL hold its last value.

Reset
REQ-030 While reset=0, all FSMs SHALL be IDLE, pointers 0, claims cleared, and every valid, ready, address and data output 0, asynchronously; in-flight transactions are discarded.
REQ-031 The first grant SHALL be possible at the first rising edge after reset deasserts.

Structure
REQ-032 The FSM state encoding (3-bit localparams) SHALL live in a shared gpu package reused by lsu and the fetcher.
REQ-033 A round-robin find-first-from-pointer sub-module, rr_pick (request vector, mask, pointer in; found and index out), SHALL be instantiated once per channel.

Verification
REQ-034 With 1 channel, consumer 3 reads address 0x10 and memory returns 0xAB with ready held high -> mem_read_valid rises 1 cycle after the request, consumer_read_ready[3]=1 with data 0xAB 2 cycles after it, and ready drops 1 cycle after valid drops.
REQ-035 With 2 channels, consumers 0, 1 and 2 all request in the same cycle -> channel 0 takes consumer 0, channel 1 takes consumer 1, and consumer 2 is granted only after a channel returns to IDLE.
REQ-036 With 1 channel and all 8 consumers holding requests continuously -> grant order is 0,1,...,7,0 with no starvation.
REQ-037 Consumer 5 asserts read and write together -> the read is served first; a write to the same address is served on the next grant.
REQ-038 reset is pulsed low during READ_WAIT -> all outputs are 0 immediately, and after reset is released the pending consumer is re-granted from pointer 0.
REQ-039 mem_write_ready is held low for 10 cycles -> mem_write_valid, address and data stay stable throughout, and the write is acked 1 cycle after ready rises.
